// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD display block.
// Contents:
//   state_e     - converter FSM states
//   SEG_0..9    - active-low 7-segment patterns (bit 0 = a ... bit 6 = g)
//   SEG_BLANK   - all segments off
//   digits_ok() - true when DIGITS decimal digits can hold any WIDTH-bit value
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // 10^digits must exceed the largest width-bit value.
  function automatic bit digits_ok(input int unsigned width, input int unsigned digits);
    longint unsigned pow;
    longint unsigned max_val;
    pow = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      pow = pow * 64'd10;
    end
    max_val = (64'd1 << width) - 64'd1;
    return pow > max_val;
  endfunction

endpackage

// File: rtl/bcd_digit_to_seg.sv
// One BCD digit to an active-low 7-segment pattern.
// Ports:
//   i_digit - BCD digit (codes 10..15 display blank)
//   i_blank - force the field dark (leading-zero suppression)
//   o_seg   - segments, bit 0 = a ... bit 6 = g, active low
module bcd_digit_to_seg
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving 7-segment fields.
// Ports:
//   CLOCK_50 - clock, rising edge
//   reset    - asynchronous, active-high
//   start    - conversion request (accepted in idle or done state)
//   bin_in   - binary value, captured on accepted start
//   busy     - high while shifting
//   done     - one-cycle pulse when bcd_out/HEX update
//   bcd_out  - BCD result, digit 0 in [3:0]
//   HEX      - active-low segment fields, digit k in [7k+6:7k]
module bin_to_bcd_display
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 16 || !digits_ok(WIDTH, DIGITS)) begin : g_param_fail
    $fatal(1, "bin_to_bcd_display: WIDTH must be 1..16 and 10^DIGITS > 2^WIDTH-1");
  end

  state_e              r_state, w_state_next;
  logic [BcdW-1:0]     r_bcd;
  logic [WIDTH-1:0]    r_bin;
  logic [CntW-1:0]     r_cnt;
  logic [BcdW-1:0]     r_bcd_out;
  logic [BcdW-1:0]     w_bcd_adj;
  logic [BcdW+WIDTH-1:0] w_shifted;
  logic                w_accept;
  logic                w_last;
  logic [DIGITS-1:0]   w_blank;
  logic                w_seen;

  // Add-3 on every digit >= 5 so the following shift carries correctly into the next digit.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_bcd_adj[4*k+:4] = (r_bcd[4*k+:4] >= 4'd5) ? r_bcd[4*k+:4] + 4'd3 : r_bcd[4*k+:4];
  end

  assign w_shifted = {w_bcd_adj, r_bin} << 1;
  assign w_accept  = start && (r_state != StShift);
  assign w_last    = (r_state == StShift) && (r_cnt == CntW'(1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = start ? StShift : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bcd_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_bin <= bin_in;
        r_bcd <= '0;
        r_cnt <= CntW'(WIDTH);
      end else if (r_state == StShift) begin
        {r_bcd, r_bin} <= w_shifted;
        r_cnt          <= r_cnt - 1'b1;
        if (w_last) r_bcd_out <= w_shifted[BcdW+WIDTH-1:WIDTH];
      end
    end
  end

  assign busy    = (r_state == StShift);
  assign done    = (r_state == StDone);
  assign bcd_out = r_bcd_out;

  // Scan from the top digit down; a digit is a leading zero until a non-zero digit is seen.
  always_comb begin
    w_blank = '0;
    w_seen  = 1'b0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      if (r_bcd_out[4*k+:4] != 4'd0) w_seen = 1'b1;
      w_blank[k] = BLANK_LZ && !w_seen;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    bcd_digit_to_seg u_seg (
      .i_digit (r_bcd_out[4*k+:4]),
      .i_blank (w_blank[k]),
      .o_seg   (HEX[7*k+:7])
    );
  end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench: vector table, corner-case sequences, exhaustive and random sweeps
// against an arithmetic reference model.
module tb_bin_to_bcd_display;

  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    int          val;
    logic [11:0] exp_bcd;
    logic [20:0] exp_hex;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy, done, busy_n, done_n;
  logic [11:0] bcd, bcd_n;
  logic [20:0] hex, hex_n;
  logic        wstart;
  logic [9:0]  wbin;
  logic        wbusy, wdone;
  logic [15:0] wbcd;
  logic [27:0] whex;

  logic [6:0]  seg_tab [10];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #10 clk = ~clk;

  bin_to_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) u_dut (
    .CLOCK_50 (clk), .reset (rst), .start (start), .bin_in (bin),
    .busy (busy), .done (done), .bcd_out (bcd), .HEX (hex)
  );

  bin_to_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) u_dut_nolz (
    .CLOCK_50 (clk), .reset (rst), .start (start), .bin_in (bin),
    .busy (busy_n), .done (done_n), .bcd_out (bcd_n), .HEX (hex_n)
  );

  bin_to_bcd_display #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1'b1)) u_dut_wide (
    .CLOCK_50 (clk), .reset (rst), .start (wstart), .bin_in (wbin),
    .busy (wbusy), .done (wdone), .bcd_out (wbcd), .HEX (whex)
  );

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] ref_bcd(input int v, input int n);
    logic [15:0] r = '0;
    for (int k = 0; k < n; k++) r[4*k+:4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  // A digit above 0 is a leading zero exactly when the value is below 10^k.
  function automatic logic [27:0] ref_hex(input int v, input int n, input bit blz);
    logic [27:0] r = '0;
    for (int k = 0; k < n; k++) begin
      if (blz && k > 0 && v < pow10(k)) r[7*k+:7] = BLK;
      else r[7*k+:7] = seg_tab[(v / pow10(k)) % 10];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Full conversion on the 8-bit instances with latency and result checks.
  task automatic run_main(input int v);
    bit lat_ok;
    @(negedge clk); start = 1'b1; bin = 8'(v);
    @(negedge clk); start = 1'b0; bin = 8'($urandom);
    lat_ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || busy_n !== 1'b1) lat_ok = 1'b0;
      @(negedge clk);
    end
    check("busy_window", 32'(lat_ok), 32'd1);
    check("done_pulse", {29'd0, busy, done, done_n}, 32'b011);
    check("bcd", 32'(bcd), 32'(ref_bcd(v, 3)));
    check("hex", 32'(hex), 32'(ref_hex(v, 3, 1'b1)));
    check("hex_nolz", 32'(hex_n), 32'(ref_hex(v, 3, 1'b0)));
    @(negedge clk);
    check("done_drop", {30'd0, busy, done}, 32'b00);
  endtask

  task automatic run_wide(input int v);
    int first;
    @(negedge clk); wstart = 1'b1; wbin = 10'(v);
    @(negedge clk); wstart = 1'b0;
    first = 0;
    for (int c = 1; c <= 30; c++) begin
      if (wdone && first == 0) first = c;
      @(negedge clk);
    end
    check("wide_done_cycle", 32'(first), 32'd11);
    check("wide_bcd", 32'(wbcd), 32'(ref_bcd(v, 4)));
    check("wide_hex", 32'(whex), 32'(ref_hex(v, 4, 1'b1)));
  endtask

  initial begin
    vec_t tbl[$];
    int   cnt, first;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    tbl.push_back('{255, 12'h255, {7'b0100100, 7'b0010010, 7'b0010010}});
    tbl.push_back('{7,   12'h007, {BLK, BLK, 7'b1111000}});
    tbl.push_back('{100, 12'h100, {7'b1111001, 7'b1000000, 7'b1000000}});
    tbl.push_back('{9,   12'h009, {BLK, BLK, 7'b0010000}});
    tbl.push_back('{0,   12'h000, {BLK, BLK, 7'b1000000}});
    tbl.push_back('{10,  12'h010, {BLK, 7'b1111001, 7'b1000000}});
    tbl.push_back('{200, 12'h200, {7'b0100100, 7'b1000000, 7'b1000000}});

    rst = 1'b1; start = 1'b0; bin = '0; wstart = 1'b0; wbin = '0;
    #1;
    check("reset_ctl", {28'd0, busy, done, busy_n, wbusy}, 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_hex", 32'(hex), {11'd0, BLK, BLK, 7'b1000000});
    check("reset_hex_nolz", 32'(hex_n), {11'd0, 7'b1000000, 7'b1000000, 7'b1000000});
    check("reset_hex_wide", 32'(whex), {4'd0, BLK, BLK, BLK, 7'b1000000});
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors with hand-written expectations.
    foreach (tbl[i]) begin
      run_main(tbl[i].val);
      check("tbl_bcd", 32'(bcd), 32'(tbl[i].exp_bcd));
      check("tbl_hex", 32'(hex), 32'(tbl[i].exp_hex));
    end

    // start during SHIFT is ignored.
    @(negedge clk); start = 1'b1; bin = 8'd100;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; bin = 8'd42;
    @(negedge clk); start = 1'b0;
    cnt = 0; first = 0;
    for (int c = 4; c <= 25; c++) begin
      if (done) begin cnt++; if (first == 0) first = c; end
      @(negedge clk);
    end
    check("ign_done_count", 32'(cnt), 32'd1);
    check("ign_done_cycle", 32'(first), 32'd9);
    check("ign_bcd", 32'(bcd), 32'h100);
    check("ign_hex1", 32'(hex[13:7]), 32'(7'b1000000));

    // Back-to-back: start accepted in the done cycle.
    @(negedge clk); start = 1'b1; bin = 8'd77;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_bcd", 32'(bcd), 32'h077);
    start = 1'b1; bin = 8'd9;
    @(negedge clk); start = 1'b0;
    check("b2b_no_gap", {30'd0, busy, done}, 32'b10);
    first = 0;
    for (int c = 10; c <= 30; c++) begin
      if (done && first == 0) first = c;
      @(negedge clk);
    end
    check("b2b_done_cycle", 32'(first), 32'd18);
    check("b2b_bcd", 32'(bcd), 32'h009);

    // Reset mid-SHIFT aborts.
    @(negedge clk); start = 1'b1; bin = 8'd200;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    check("abort_ctl", {28'd0, busy, done, busy_n, done_n}, 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_hex", 32'(hex), {11'd0, BLK, BLK, 7'b1000000});
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (done || done_n) cnt++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    run_main(200);

    // Wider instance.
    run_wide(1023);
    for (int i = 0; i < 4; i++) run_wide(int'($urandom_range(0, 1023)));

    // Exhaustive sweep, then random values.
    for (int v = 0; v < 256; v++) run_main(v);
    for (int i = 0; i < 40; i++) run_main(int'($urandom_range(0, 255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
